// File: rtl/dmem_arbiter_pkg.sv
// Shared constants and the owner-tag encoding used to route read responses
// from the single memory port back to the fetch or data requester.
package dmem_arbiter_pkg;

    localparam int DEF_XLEN         = 32;
    localparam int DEF_MAX_D_STREAK = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } ownTag_t;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Core-side request/response bus (fetch + data ports) and the memory-macro bus.
// The master side drives requests; the slave side answers them.
interface dmem_arbiter_if #(
    parameter int XLEN = dmem_arbiter_pkg::DEF_XLEN
);
    logic            i_req;
    logic [XLEN-1:0] i_addr;
    logic            i_ready;
    logic            i_rvalid;
    logic [XLEN-1:0] i_rdata;
    logic            stall_if;
    logic            d_req;
    logic [3:0]      d_we;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic            d_ready;
    logic            d_rvalid;
    logic [XLEN-1:0] d_rdata;
    logic            stall_mem;

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        input  i_ready, i_rvalid, i_rdata, stall_if,
        input  d_ready, d_rvalid, d_rdata, stall_mem
    );

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata,
        output i_ready, i_rvalid, i_rdata, stall_if,
        output d_ready, d_rvalid, d_rdata, stall_mem
    );
endinterface

interface dmem_mem_if #(
    parameter int XLEN = dmem_arbiter_pkg::DEF_XLEN
);
    logic            mem_en;
    logic [3:0]      mem_we;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [XLEN-1:0] mem_rdata;

    modport master (
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter_resp_tag_pipe.sv
// RD_LATENCY-deep shift register of owner tags; the oldest tag lines up with
// the memory read data for the access that produced it.
module dmem_arbiter_resp_tag_pipe
    import dmem_arbiter_pkg::*;
#(
    parameter int RD_LATENCY = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  ownTag_t tagIn,
    output ownTag_t tagOut
);

    ownTag_t tagStage [RD_LATENCY];

    // Reset flushes in-flight tags so no stale rvalid survives a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < RD_LATENCY; k++) tagStage[k] <= OWN_NONE;
        end else begin
            tagStage[0] <= tagIn;
            for (int k = 1; k < RD_LATENCY; k++) tagStage[k] <= tagStage[k-1];
        end
    end

    assign tagOut = tagStage[RD_LATENCY-1];

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates one single-ported memory between fetch (I) and data (D) requesters.
// D wins conflicts, but after MAX_D_STREAK consecutive wins a waiting fetch is forced through.
module dmem_arbiter #(
    parameter int XLEN         = dmem_arbiter_pkg::DEF_XLEN,
    parameter int RD_LATENCY   = 1,
    parameter int MAX_D_STREAK = dmem_arbiter_pkg::DEF_MAX_D_STREAK
) (
    input logic           clk,
    input logic           rst_n,
    dmem_arbiter_if.slave core,
    dmem_mem_if.master    mem
);
    import dmem_arbiter_pkg::*;

    localparam logic [3:0]      STREAK_MAX = 4'(MAX_D_STREAK);
    localparam logic [XLEN-1:0] ZERO_WORD  = '0;

    logic       grantI;
    logic       grantD;
    logic [3:0] streak;
    logic [3:0] streakNext;
    ownTag_t    tagIn;
    ownTag_t    tagOut;

    function automatic logic [3:0] satInc(input logic [3:0] v);
        return (v == STREAK_MAX) ? v : v + 4'd1;
    endfunction

    always_comb begin
        grantD = core.d_req & (~core.i_req | (streak != STREAK_MAX));
        grantI = core.i_req & ~grantD;
    end

    // The streak only measures D wins while a fetch is actually waiting.
    always_comb begin
        streakNext = streak;
        if (!core.i_req || grantI) begin
            streakNext = '0;
        end else if (grantD) begin
            streakNext = satInc(streak);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak <= '0;
        end else begin
            streak <= streakNext;
        end
    end

    always_comb begin
        mem.mem_en    = 1'b0;
        mem.mem_we    = 4'h0;
        mem.mem_addr  = ZERO_WORD;
        mem.mem_wdata = ZERO_WORD;
        tagIn         = OWN_NONE;
        if (grantD) begin
            mem.mem_en    = 1'b1;
            mem.mem_we    = core.d_we;
            mem.mem_addr  = core.d_addr;
            mem.mem_wdata = core.d_wdata;
            tagIn         = (core.d_we == 4'h0) ? OWN_D : OWN_NONE;
        end else if (grantI) begin
            mem.mem_en   = 1'b1;
            mem.mem_addr = core.i_addr;
            tagIn        = OWN_I;
        end
    end

    dmem_arbiter_resp_tag_pipe #(
        .RD_LATENCY(RD_LATENCY)
    ) u_tagPipe (
        .clk    (clk),
        .rst_n  (rst_n),
        .tagIn  (tagIn),
        .tagOut (tagOut)
    );

    assign core.i_ready   = grantI;
    assign core.d_ready   = grantD;
    assign core.stall_if  = core.i_req & ~grantI;
    assign core.stall_mem = core.d_req & ~grantD;
    assign core.i_rvalid  = (tagOut == OWN_I);
    assign core.d_rvalid  = (tagOut == OWN_D);
    assign core.i_rdata   = mem.mem_rdata;
    assign core.d_rdata   = mem.mem_rdata;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares one single-ported synchronous data/instruction memory (byte-write-enable BRAM) between two requesters: the instruction-fetch port (I) and the memory-stage data port (D).
- D carries the byte-lane write enables and shifted store data that the memory stage generates.
- Grants at most one access per cycle, routes read data back with the memory's fixed read latency, and raises per-port stall signals for the hazard logic.
- Sits between the core pipeline and the memory macro.

Parameters:
- XLEN, 32, address/data width.
- RD_LATENCY, 1, memory read latency in cycles (1..3).
- MAX_D_STREAK, 4, consecutive D grants allowed while I is waiting before I is forced through (1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_req  in  1  fetch request (read only).
- i_addr  in  XLEN  fetch byte address.
- i_ready  out  1  fetch granted this cycle.
- i_rvalid  out  1  fetch read data valid.
- i_rdata  out  XLEN  fetch read data.
- stall_if  out  1  i_req & ~i_ready.
- d_req  in  1  data request.
- d_we  in  4  byte write enables; 0 means read.
- d_addr  in  XLEN  data byte address.
- d_wdata  in  XLEN  store data, already lane-shifted.
- d_ready  out  1  data granted this cycle.
- d_rvalid  out  1  load read data valid.
- d_rdata  out  XLEN  load read data.
- stall_mem  out  1  d_req & ~d_ready.
- mem_en  out  1  memory enable.
- mem_we  out  4  memory byte write enables.
- mem_addr  out  XLEN  memory address.
- mem_wdata  out  XLEN  memory write data.
- mem_rdata  in  XLEN  memory read data, RD_LATENCY after mem_en.

Behaviour:
- Reset (rst_n low, asynchronous):
  - streak counter = 0; all tag pipeline stages = NONE.
  - i_rvalid = d_rvalid = 0.
  - Combinational outputs follow the request rules below with zeroed state.
- Grant is combinational in the request cycle (zero added latency):
  - Only one requester: it is granted.
  - Both requesting: D is granted unless streak == MAX_D_STREAK, in which case I is granted.
  - Neither requesting: no grant.
- Streak counter, updated on the clock edge:
  - +1 when D is granted while i_req = 1 (saturates at MAX_D_STREAK).
  - Cleared when I is granted, or when i_req = 0.
  - Otherwise held.
- Memory drive:
  - D granted: mem_en = 1, mem_we = d_we, mem_addr = d_addr, mem_wdata = d_wdata.
  - I granted: mem_en = 1, mem_we = 0, mem_addr = i_addr, mem_wdata = 0.
  - No grant: mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0.
- Response routing:
  - A tag (NONE/I/D) enters a RD_LATENCY-deep shift register every cycle.
  - Tag = I on an I grant; D on a D grant with d_we == 0; NONE otherwise. Stores never produce rvalid.
  - At the pipeline output: tag I gives i_rvalid = 1; tag D gives d_rvalid = 1.
  - i_rdata and d_rdata both equal mem_rdata unconditionally; consumers qualify with rvalid.
  - Exactly one rvalid per granted read, exactly RD_LATENCY cycles after the grant. Back-to-back reads are fully pipelined, one per cycle.
- Requester rule: a request must hold its address and data stable until ready is seen. A dropped request is legal and consumes nothing.
- d_we == 4'b0000 with d_req is a read. Any nonzero byte pattern is passed through unchanged; there is no alignment checking.
- Reset asserted mid-operation: in-flight tags are flushed, so no rvalid appears after reset deasserts for reads granted before it. The streak counter restarts at 0.
- Simultaneous store by D and fetch by I: this is an ordinary conflict, and the arbitration rules above apply.

Decomposition:
- Shared defines/package (defines.v):
  - XLEN.
  - Owner tag encoding: OWN_NONE = 2'd0, OWN_I = 2'd1, OWN_D = 2'd2.
  - MAX_D_STREAK default.
- Sub-module resp_tag_pipe:
  - Parameterised RD_LATENCY-deep, 2-bit-wide shift register with async active-low clear.
  - Outputs the oldest tag.
- The top level holds the grant logic, the streak counter and the output muxes.

Test Plan:
- Reset, then i_req = 1, i_addr = 0x100, d_req = 0 -> i_ready = 1 and mem_addr = 0x100 the same cycle; i_rvalid = 1 RD_LATENCY cycles later with i_rdata = memory[0x100].
- Conflict: i_req = d_req = 1, d_we = 0, d_addr = 0x2000, held for 10 cycles, MAX_D_STREAK = 4 -> D granted on cycles 0-3; I granted on cycle 4 with stall_mem = 1 on that cycle; D granted on cycles 5-8; I granted on cycle 9.
- Store: d_req = 1, d_we = 4'b1100, d_wdata = 0xABCD0000, d_addr = 0x40 -> mem_we = 4'b1100 the same cycle; no d_rvalid; a later read of 0x40 returns 0xABCDxxxx with the low half unchanged.
- Pipelined reads: RD_LATENCY = 2, alternating I and D reads for 6 cycles -> rvalids alternate on the matching ports 2 cycles after each grant; no gaps, no misrouting.
- rst_n pulsed low for 1 cycle while 1-2 reads are in flight -> i_rvalid and d_rvalid stay 0 until the next granted read completes; streak counter = 0 after reset.
- Idle: i_req = d_req = 0 -> mem_en = 0, mem_we = 0, mem_addr = 0, both stalls 0.
